// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: captures MEM results, extracts
// and extends load data, drives the register-file write port and a retire counter.
module mem_wb_stage #(
  parameter int CNT_W       = 32,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_wb,
  input  logic             flush_wb,
  input  logic             valid_mem,
  input  logic [31:0]      alu_result_mem1,
  input  logic [4:0]       rd_mem_out1,
  input  logic             regwrite_mem_out1,
  input  logic [31:0]      mem_data_mem1,
  input  logic             memtoreg_mem,
  input  logic [2:0]       loadtype_ex_mem,
  output logic [4:0]       rd_wb,
  output logic             regwrite_wb,
  output logic [31:0]      wb_data,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_q;
  logic [4:0]       rd_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic [2:0]       loadtype_q;
  logic [1:0]       addr_q;
  logic [31:0]      alu_q;
  logic [31:0]      mem_q;
  logic [CNT_W-1:0] cnt_q;

  // The current occupant retires on any unstalled edge, even when a flush
  // replaces it with a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      loadtype_q <= 3'd0;
      addr_q     <= 2'd0;
      alu_q      <= 32'd0;
      mem_q      <= 32'd0;
      cnt_q      <= '0;
    end else begin
      if (valid_q && !stall_wb) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (flush_wb) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
      end else if (!stall_wb) begin
        valid_q    <= valid_mem;
        rd_q       <= rd_mem_out1;
        regwrite_q <= regwrite_mem_out1 & valid_mem;
        memtoreg_q <= memtoreg_mem;
        loadtype_q <= loadtype_ex_mem;
        addr_q     <= alu_result_mem1[1:0];
        alu_q      <= alu_result_mem1;
        mem_q      <= mem_data_mem1;
      end
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  always_comb begin
    byte_sel = mem_q[7:0];
    case (addr_q)
      2'd0: byte_sel = mem_q[7:0];
      2'd1: byte_sel = mem_q[15:8];
      2'd2: byte_sel = mem_q[23:16];
      2'd3: byte_sel = mem_q[31:24];
      default: byte_sel = mem_q[7:0];
    endcase
    half_sel = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
  end

  // Halfword loads ignore addr[0]; unknown encodings behave like LW.
  always_comb begin
    load_val = mem_q;
    case (loadtype_q)
      LT_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_val = {24'd0, byte_sel};
      LT_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_val = {16'd0, half_sel};
      default: load_val = mem_q;
    endcase
  end

  assign wb_data      = memtoreg_q ? load_val : alu_q;
  assign rd_wb        = rd_q;
  assign wb_valid     = valid_q;
  assign regwrite_wb  = valid_q & regwrite_q & ~(SUPPRESS_X0 && (rd_q == 5'd0));
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table-driven load vectors, directed stall/flush/reset/wrap
// sequences and random traffic against a behavioural model of the WB register.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_wb, flush_wb, valid_mem;
  logic [31:0] alu_result_mem1, mem_data_mem1;
  logic [4:0]  rd_mem_out1;
  logic        regwrite_mem_out1, memtoreg_mem;
  logic [2:0]  loadtype_ex_mem;

  logic [4:0]  rd_wb, rd_wb4;
  logic        regwrite_wb, regwrite_wb4, wb_valid, wb_valid4;
  logic [31:0] wb_data, wb_data4;
  logic [31:0] retire_count;
  logic [3:0]  retire_count4;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .valid_mem(valid_mem), .alu_result_mem1(alu_result_mem1),
    .rd_mem_out1(rd_mem_out1), .regwrite_mem_out1(regwrite_mem_out1),
    .mem_data_mem1(mem_data_mem1), .memtoreg_mem(memtoreg_mem),
    .loadtype_ex_mem(loadtype_ex_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
    .wb_data(wb_data), .wb_valid(wb_valid), .retire_count(retire_count)
  );

  mem_wb_stage #(.CNT_W(4), .SUPPRESS_X0(1'b0)) dut4 (
    .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .valid_mem(valid_mem), .alu_result_mem1(alu_result_mem1),
    .rd_mem_out1(rd_mem_out1), .regwrite_mem_out1(regwrite_mem_out1),
    .mem_data_mem1(mem_data_mem1), .memtoreg_mem(memtoreg_mem),
    .loadtype_ex_mem(loadtype_ex_mem), .rd_wb(rd_wb4), .regwrite_wb(regwrite_wb4),
    .wb_data(wb_data4), .wb_valid(wb_valid4), .retire_count(retire_count4)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: the instruction currently sitting in WB plus a retire tally.
  logic        m_valid, m_write, m_memtoreg;
  logic [4:0]  m_rd;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_mem;
  longint unsigned m_retired;

  function automatic logic [31:0] load_value(input logic [31:0] word,
                                             input logic [31:0] addr,
                                             input logic [2:0] lt);
    logic [31:0] b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr % 4) / 2))) % 65536;
    case (lt)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    logic [31:0] exp_data;
    exp_data = m_memtoreg ? load_value(m_mem, m_alu, m_lt) : m_alu;
    check("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
    check("rd_wb", {27'd0, rd_wb}, {27'd0, m_rd});
    check("wb_data", wb_data, exp_data);
    check("regwrite_wb", {31'd0, regwrite_wb}, {31'd0, m_valid & m_write & (m_rd != 0)});
    check("retire_count", retire_count, 32'(m_retired % 64'h1_0000_0000));
    check("wb_data4", wb_data4, exp_data);
    check("regwrite_wb4", {31'd0, regwrite_wb4}, {31'd0, m_valid & m_write});
    check("retire_count4", {28'd0, retire_count4}, 32'(m_retired % 16));
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                      input logic [31:0] md, input logic mt, input logic [2:0] lt);
    rst = r; stall_wb = st; flush_wb = fl; valid_mem = v;
    alu_result_mem1 = alu; rd_mem_out1 = rd; regwrite_mem_out1 = rw;
    mem_data_mem1 = md; memtoreg_mem = mt; loadtype_ex_mem = lt;
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_write = 0; m_memtoreg = 0; m_rd = 0; m_lt = 0;
      m_alu = 0; m_mem = 0; m_retired = 0;
    end else begin
      if (m_valid && !st) m_retired++;
      if (fl) begin
        m_valid = 0; m_write = 0; m_memtoreg = 0;
      end else if (!st) begin
        m_valid = v; m_write = v & rw; m_memtoreg = mt; m_rd = rd;
        m_lt = lt; m_alu = alu; m_mem = md;
      end
    end
    #1;
    check_all();
  endtask

  task automatic step_rand(input logic r, input logic st, input logic fl);
    step(r, st, fl, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
         1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
         3'($urandom_range(0, 7)));
  endtask

  task automatic do_reset();
    step_rand(1'b0, 1'b0, 1'b0);
    step_rand(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  lt;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[5];
  logic [31:0] held_data;
  logic [31:0] held_cnt;

  initial begin
    vecs[0] = '{"lb_a3",  32'h0000_1003, 3'b000, 32'hFFFF_FF80};
    vecs[1] = '{"lbu_a1", 32'h0000_1001, 3'b100, 32'h0000_007F};
    vecs[2] = '{"lh_a2",  32'h0000_1002, 3'b001, 32'hFFFF_80FF};
    vecs[3] = '{"lhu_a0", 32'h0000_1000, 3'b101, 32'h0000_7F01};
    vecs[4] = '{"lw",     32'h0000_1002, 3'b010, 32'h80FF_7F01};

    // Reset with arbitrary inputs (including stall and flush high)
    step_rand(1'b0, 1'b1, 1'b0);
    step_rand(1'b0, 1'b0, 1'b1);
    check("rst_data", wb_data, 32'd0);
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_cnt", retire_count, 32'd0);

    // ALU write-back, first capture after release
    step(1, 0, 0, 1, 32'h0000_1234, 5'd5, 1, 32'hDEAD_BEEF, 0, 3'b010);
    check("alu_rd", {27'd0, rd_wb}, 32'd5);
    check("alu_data", wb_data, 32'h0000_1234);
    check("alu_we", {31'd0, regwrite_wb}, 32'd1);
    check("alu_cnt0", retire_count, 32'd0);
    step(1, 0, 0, 0, 32'h0, 5'd0, 0, 32'h0, 0, 3'b000);
    check("alu_cnt1", retire_count, 32'd1);

    // Table-driven load extraction
    foreach (vecs[i]) begin
      step(1, 0, 0, 1, vecs[i].addr, 5'd7, 1, 32'h80FF_7F01, 1, vecs[i].lt);
      check(vecs[i].name, wb_data, vecs[i].exp);
    end

    // x0 write: valid, not written, still retires
    step(1, 0, 0, 1, 32'h55, 5'd0, 1, 32'h0, 0, 3'b010);
    check("x0_we", {31'd0, regwrite_wb}, 32'd0);
    check("x0_valid", {31'd0, wb_valid}, 32'd1);
    held_cnt = retire_count;
    step(1, 0, 0, 0, 32'h0, 5'd1, 0, 32'h0, 0, 3'b000);
    check("x0_retire", retire_count, held_cnt + 32'd1);

    // Stall three cycles while inputs change
    step(1, 0, 0, 1, 32'hCAFE_0004, 5'd9, 1, 32'h0, 0, 3'b010);
    held_data = wb_data;
    held_cnt  = retire_count;
    for (int i = 0; i < 3; i++) step_rand(1'b1, 1'b1, 1'b0);
    check("stall_data", wb_data, held_data);
    check("stall_cnt", retire_count, held_cnt);
    check("stall_we", {31'd0, regwrite_wb}, 32'd1);

    // Stall and flush together: bubble loaded, occupant not counted
    step(1, 1, 1, 1, 32'h1111, 5'd3, 1, 32'h0, 0, 3'b010);
    check("sf_valid", {31'd0, wb_valid}, 32'd0);
    check("sf_we", {31'd0, regwrite_wb}, 32'd0);
    check("sf_cnt", retire_count, held_cnt);

    // Flush alone: occupant still retires
    step(1, 0, 0, 1, 32'h2222, 5'd4, 1, 32'h0, 0, 3'b010);
    held_cnt = retire_count;
    step(1, 0, 1, 1, 32'h3333, 5'd6, 1, 32'h0, 0, 3'b010);
    check("flush_cnt", retire_count, held_cnt + 32'd1);

    // Reset mid-stall
    step(1, 0, 0, 1, 32'h4444, 5'd8, 1, 32'h0, 0, 3'b010);
    step(0, 1, 0, 1, 32'h5555, 5'd8, 1, 32'h0, 0, 3'b010);
    check("rst_stall_valid", {31'd0, wb_valid}, 32'd0);

    // Counter wrap on the 4-bit instance: 17 back-to-back retirements
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      step(1, 0, 0, (k <= 17), 32'(k), 5'd2, 1, 32'h0, 0, 3'b010);
      check("wrap_cnt4", {28'd0, retire_count4}, 32'((k - 1) % 16));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step_rand(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and write-back stage sitting directly downstream of the MEM stage.
- Captures the MEM outputs (ALU result, rd, regwrite, raw memory word, memtoreg) together with the load type from the EX/MEM register.
- Extracts and sign- or zero-extends the addressed byte or halfword, and selects the register-file write-back data.
- Provides forwarding signals and a retired-instruction counter for the hazard unit and FPGA debug.

Parameters:
- CNT_W, 32, width of retire_count; wraps modulo 2^CNT_W.
- SUPPRESS_X0, 1, when 1 regwrite_wb is forced low for rd=0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- stall_wb  input  1  hold current WB contents, ignore inputs.
- flush_wb  input  1  load a bubble instead of the inputs.
- valid_mem  input  1  MEM stage holds a real instruction.
- alu_result_mem1  input  32  ALU result / memory byte address from MEM.
- rd_mem_out1  input  5  destination register.
- regwrite_mem_out1  input  1  instruction writes a register.
- mem_data_mem1  input  32  raw word read from data memory.
- memtoreg_mem  input  1  1 = write-back from memory, 0 = from ALU.
- loadtype_ex_mem  input  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- rd_wb  output  5  register-file write address.
- regwrite_wb  output  1  register-file write enable.
- wb_data  output  32  register-file write data; also the forwarding value.
- wb_valid  output  1  WB holds a real instruction.
- retire_count  output  CNT_W  number of instructions retired.

Behaviour:
- Registered fields: valid, rd, regwrite, memtoreg, loadtype, addr[1:0], alu_result, mem_data.
- Priority at each posedge: reset > flush > stall > capture.
  - Reset (rst=0): all registered fields clear to 0 and retire_count is 0, so every output is 0.
  - flush_wb=1: valid, regwrite and memtoreg clear to 0; other fields are don't-care. Flush wins over a simultaneous stall.
  - stall_wb=1 (no flush): all fields hold their values.
  - Otherwise: capture the inputs. If valid_mem=0, regwrite is captured as 0.
- Latency: one cycle. Inputs present before edge N appear on the outputs after edge N. All outputs are combinational from the registered fields only; there is no input-to-output combinational path.
- Load extraction operates on the registered mem_data, using byte lane addr[1:0]:
  - LB: sign-extend byte[addr[1:0]].
  - LBU: zero-extend byte[addr[1:0]].
  - LH: sign-extend half[addr[1]]; addr[0] is ignored (no misaligned trap).
  - LHU: zero-extend half[addr[1]].
  - LW, and every other loadtype encoding: the full word; addr[1:0] is ignored.
  - Byte 0 is mem_data[7:0] (little-endian).
- wb_data = memtoreg ? extracted load value : alu_result.
- rd_wb = registered rd.
- wb_valid = registered valid.
- regwrite_wb = valid & regwrite & !(SUPPRESS_X0 && rd==0).
- While stalled, regwrite_wb stays asserted with unchanged rd and data. Repeated register-file writes are idempotent and permitted.
- retire_count increments by 1 at any posedge where the registered valid=1 and stall_wb=0. flush_wb does not block this, because the current occupant still retires. It wraps from all-ones to 0 and resets to 0.
- Reset asserted mid-stall or mid-flush: reset wins; the bubble state is reached in one cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with arbitrary inputs -> all outputs 0, retire_count=0; release -> first valid capture appears one cycle later.
- ALU write-back: valid_mem=1, regwrite=1, memtoreg=0, rd=5, alu_result=0x0000_1234 -> next cycle rd_wb=5, wb_data=0x0000_1234, regwrite_wb=1, retire_count=1 after the following edge.
- Load extraction: mem_data=0x80FF_7F01, memtoreg=1, then:
  - LB, addr=0x3 -> wb_data=0xFFFF_FF80.
  - LBU, addr=0x1 -> wb_data=0x0000_007F.
  - LH, addr=0x2 -> wb_data=0xFFFF_80FF.
  - LHU, addr=0x0 -> wb_data=0x0000_7F01.
  - LW -> wb_data=0x80FF_7F01.
- x0 suppression: valid write to rd=0 -> regwrite_wb=0, wb_valid=1, retire_count still increments.
- Stall/flush:
  - stall_wb=1 for 3 cycles while inputs change -> outputs frozen and retire_count unchanged.
  - stall and flush asserted together -> bubble loaded (wb_valid=0, regwrite_wb=0), and the prior occupant is not counted because stall was high.
- Counter wrap: CNT_W=4, retire 17 consecutive valid instructions -> retire_count reaches 15, then 0, then 1.
